// File: rtl/id_exe_stage.sv
// id_exe_stage: ID/EX pipeline register with MEM/WB operand forwarding, immediate select and load-use detect.
// Latency: 1 cycle from ID fields to ALU-facing outputs; forwarding muxes and hazard_stall are combinational.
// Backpressure: no handshake; freeze holds the stage (operands keep tracking forwards), flush inserts a bubble.
module id_exe_stage #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int EXE_CMD_LEN  = 4,
    parameter bit FORWARD_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [REG_ADDR_LEN-1:0] src1_in,
    input  logic [REG_ADDR_LEN-1:0] src2_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic [WORD_LEN-1:0]     reg1_in,
    input  logic [WORD_LEN-1:0]     reg2_in,
    input  logic [WORD_LEN-1:0]     imm_in,
    input  logic                    is_imm_in,
    input  logic [EXE_CMD_LEN-1:0]  exe_cmd_in,
    input  logic                    mem_read_in,
    input  logic                    mem_write_in,
    input  logic                    wb_en_in,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_src2_used,
    input  logic                    mem_fwd_en,
    input  logic [REG_ADDR_LEN-1:0] mem_fwd_dest,
    input  logic [WORD_LEN-1:0]     mem_fwd_val,
    input  logic                    wb_fwd_en,
    input  logic [REG_ADDR_LEN-1:0] wb_fwd_dest,
    input  logic [WORD_LEN-1:0]     wb_fwd_val,
    output logic [WORD_LEN-1:0]     val1,
    output logic [WORD_LEN-1:0]     val2,
    output logic [EXE_CMD_LEN-1:0]  EXE_CMD,
    output logic [WORD_LEN-1:0]     st_val,
    output logic [REG_ADDR_LEN-1:0] dest,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    wb_en,
    output logic                    valid,
    output logic                    hazard_stall
);

    // Everything the stage holds for one instruction; an all-zero value is a harmless bubble.
    typedef struct packed {
        logic                    valid;
        logic [REG_ADDR_LEN-1:0] src1;
        logic [REG_ADDR_LEN-1:0] src2;
        logic [REG_ADDR_LEN-1:0] dest;
        logic [WORD_LEN-1:0]     reg1;
        logic [WORD_LEN-1:0]     reg2;
        logic [WORD_LEN-1:0]     imm;
        logic                    is_imm;
        logic [EXE_CMD_LEN-1:0]  exe_cmd;
        logic                    mem_read;
        logic                    mem_write;
        logic                    wb_en;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;
    stage_t load_val;

    logic                mem_hit1;
    logic                mem_hit2;
    logic                wb_hit1;
    logic                wb_hit2;
    logic [WORD_LEN-1:0] fwd1;
    logic [WORD_LEN-1:0] fwd2;
    logic                src_match;
    logic                producer;

    // Register 0 is hard-wired zero, so a "write" to it must never be forwarded.
    assign mem_hit1 = FORWARD_EN && mem_fwd_en && (mem_fwd_dest == stage_q.src1) && (stage_q.src1 != '0);
    assign mem_hit2 = FORWARD_EN && mem_fwd_en && (mem_fwd_dest == stage_q.src2) && (stage_q.src2 != '0);
    assign wb_hit1  = FORWARD_EN && wb_fwd_en  && (wb_fwd_dest  == stage_q.src1) && (stage_q.src1 != '0);
    assign wb_hit2  = FORWARD_EN && wb_fwd_en  && (wb_fwd_dest  == stage_q.src2) && (stage_q.src2 != '0);

    // Operand forwarding: MEM holds the younger result so it wins over WB.
    always_comb begin
        fwd1 = stage_q.reg1;
        fwd2 = stage_q.reg2;
        if (mem_hit1) begin
            fwd1 = mem_fwd_val;
        end else if (wb_hit1) begin
            fwd1 = wb_fwd_val;
        end
        if (mem_hit2) begin
            fwd2 = mem_fwd_val;
        end else if (wb_hit2) begin
            fwd2 = wb_fwd_val;
        end
    end

    // Snapshot of the ID-stage fields for a normal load.
    always_comb begin
        load_val           = '0;
        load_val.valid     = 1'b1;
        load_val.src1      = src1_in;
        load_val.src2      = src2_in;
        load_val.dest      = dest_in;
        load_val.reg1      = reg1_in;
        load_val.reg2      = reg2_in;
        load_val.imm       = imm_in;
        load_val.is_imm    = is_imm_in;
        load_val.exe_cmd   = exe_cmd_in;
        load_val.mem_read  = mem_read_in;
        load_val.mem_write = mem_write_in;
        load_val.wb_en     = wb_en_in;
    end

    // Next-state select: flush beats freeze; a held instruction re-captures its forwarded
    // operands every cycle so a producer that retires during the freeze is not lost.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (freeze) begin
            stage_d.reg1 = fwd1;
            stage_d.reg2 = fwd2;
        end else if (!in_valid) begin
            stage_d = '0;
        end else begin
            stage_d = load_val;
        end
    end

    // Stage register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Load-use detect; without forwarding any pending write to a needed register must stall.
    always_comb begin
        src_match    = (id_src1 == stage_q.dest) || (id_src2_used && (id_src2 == stage_q.dest));
        producer     = stage_q.mem_read || (!FORWARD_EN && stage_q.wb_en);
        hazard_stall = stage_q.valid && producer && (stage_q.dest != '0) && src_match;
    end

    assign val1      = fwd1;
    assign val2      = stage_q.is_imm ? stage_q.imm : fwd2;
    assign st_val    = fwd2;
    assign EXE_CMD   = stage_q.exe_cmd;
    assign dest      = stage_q.dest;
    assign mem_read  = stage_q.mem_read;
    assign mem_write = stage_q.mem_write;
    assign wb_en     = stage_q.wb_en;
    assign valid     = stage_q.valid;

endmodule

// File: tb/tb_id_exe_stage.sv
// tb_id_exe_stage: drives two instances (forwarding on and off) from shared inputs.
// Expected outputs come from an instruction-level model of the stage kept in the bench.
// Directed scenarios first, then a randomized run compared every cycle.
module tb_id_exe_stage;

    localparam logic [3:0] CMD_ADD = 4'h1;
    localparam logic [3:0] CMD_LW  = 4'h2;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, in_valid;
    logic [4:0]  src1_in, src2_in, dest_in;
    logic [31:0] reg1_in, reg2_in, imm_in;
    logic        is_imm_in;
    logic [3:0]  exe_cmd_in;
    logic        mem_read_in, mem_write_in, wb_en_in;
    logic [4:0]  id_src1, id_src2;
    logic        id_src2_used;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_dest, wb_fwd_dest;
    logic [31:0] mem_fwd_val, wb_fwd_val;

    logic [31:0] a_val1, a_val2, a_st_val, b_val1, b_val2, b_st_val;
    logic [3:0]  a_cmd, b_cmd;
    logic [4:0]  a_dest, b_dest;
    logic        a_mr, a_mw, a_wb, a_valid, a_haz;
    logic        b_mr, b_mw, b_wb, b_valid, b_haz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_exe_stage #(.WORD_LEN(32), .REG_ADDR_LEN(5), .EXE_CMD_LEN(4), .FORWARD_EN(1'b1)) dut_fwd (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
        .reg1_in(reg1_in), .reg2_in(reg2_in), .imm_in(imm_in), .is_imm_in(is_imm_in),
        .exe_cmd_in(exe_cmd_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wb_en_in(wb_en_in), .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_dest(mem_fwd_dest), .mem_fwd_val(mem_fwd_val),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_val(wb_fwd_val),
        .val1(a_val1), .val2(a_val2), .EXE_CMD(a_cmd), .st_val(a_st_val), .dest(a_dest),
        .mem_read(a_mr), .mem_write(a_mw), .wb_en(a_wb), .valid(a_valid), .hazard_stall(a_haz)
    );

    id_exe_stage #(.WORD_LEN(32), .REG_ADDR_LEN(5), .EXE_CMD_LEN(4), .FORWARD_EN(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
        .reg1_in(reg1_in), .reg2_in(reg2_in), .imm_in(imm_in), .is_imm_in(is_imm_in),
        .exe_cmd_in(exe_cmd_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wb_en_in(wb_en_in), .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_dest(mem_fwd_dest), .mem_fwd_val(mem_fwd_val),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_val(wb_fwd_val),
        .val1(b_val1), .val2(b_val2), .EXE_CMD(b_cmd), .st_val(b_st_val), .dest(b_dest),
        .mem_read(b_mr), .mem_write(b_mw), .wb_en(b_wb), .valid(b_valid), .hazard_stall(b_haz)
    );

    // Instruction held by the stage, as the model sees it.
    typedef struct packed {
        logic        valid;
        logic [4:0]  src1, src2, dest;
        logic [31:0] reg1, reg2, imm;
        logic        is_imm;
        logic [3:0]  cmd;
        logic        mr, mw, wb;
    } inst_t;

    // All observable outputs in one vector.
    typedef struct packed {
        logic [31:0] val1, val2, st_val;
        logic [3:0]  cmd;
        logic [4:0]  dest;
        logic        mr, mw, wb, valid, haz;
    } out_t;

    inst_t m_fwd, m_raw;

    function automatic logic [31:0] ref_operand(input bit fe, input logic [4:0] src, input logic [31:0] rv);
        if (fe && src != 0 && mem_fwd_en && mem_fwd_dest == src) return mem_fwd_val;
        if (fe && src != 0 && wb_fwd_en && wb_fwd_dest == src) return wb_fwd_val;
        return rv;
    endfunction

    function automatic out_t ref_out(input bit fe, input inst_t m);
        out_t o;
        logic needs;
        o.val1   = ref_operand(fe, m.src1, m.reg1);
        o.st_val = ref_operand(fe, m.src2, m.reg2);
        o.val2   = m.is_imm ? m.imm : o.st_val;
        o.cmd    = m.cmd;
        o.dest   = m.dest;
        o.mr     = m.mr;
        o.mw     = m.mw;
        o.wb     = m.wb;
        o.valid  = m.valid;
        needs    = (id_src1 == m.dest) || (id_src2_used && id_src2 == m.dest);
        o.haz    = m.valid && m.dest != 0 && needs && (m.mr || (!fe && m.wb));
        return o;
    endfunction

    function automatic inst_t ref_next(input bit fe, input inst_t m);
        inst_t n;
        if (rst || flush) return '0;
        if (freeze) begin
            n = m;
            n.reg1 = ref_operand(fe, m.src1, m.reg1);
            n.reg2 = ref_operand(fe, m.src2, m.reg2);
            return n;
        end
        if (!in_valid) return '0;
        n = '{valid: 1'b1, src1: src1_in, src2: src2_in, dest: dest_in, reg1: reg1_in,
              reg2: reg2_in, imm: imm_in, is_imm: is_imm_in, cmd: exe_cmd_in,
              mr: mem_read_in, mw: mem_write_in, wb: wb_en_in};
        return n;
    endfunction

    function automatic out_t obs_fwd();
        return '{val1: a_val1, val2: a_val2, st_val: a_st_val, cmd: a_cmd, dest: a_dest,
                 mr: a_mr, mw: a_mw, wb: a_wb, valid: a_valid, haz: a_haz};
    endfunction

    function automatic out_t obs_raw();
        return '{val1: b_val1, val2: b_val2, st_val: b_st_val, cmd: b_cmd, dest: b_dest,
                 mr: b_mr, mw: b_mw, wb: b_wb, valid: b_valid, haz: b_haz};
    endfunction

    // Advance one clock edge, moving both models with the inputs present before the edge.
    task automatic tick();
        inst_t nf, nr;
        nf = ref_next(1'b1, m_fwd);
        nr = ref_next(1'b0, m_raw);
        @(posedge clk);
        #1;
        m_fwd = nf;
        m_raw = nr;
    endtask

    task automatic idle_inputs();
        rst = 0; freeze = 0; flush = 0; in_valid = 0;
        src1_in = 0; src2_in = 0; dest_in = 0; reg1_in = 0; reg2_in = 0; imm_in = 0;
        is_imm_in = 0; exe_cmd_in = 0; mem_read_in = 0; mem_write_in = 0; wb_en_in = 0;
        id_src1 = 0; id_src2 = 0; id_src2_used = 0;
        mem_fwd_en = 0; mem_fwd_dest = 0; mem_fwd_val = 0;
        wb_fwd_en = 0; wb_fwd_dest = 0; wb_fwd_val = 0;
    endtask

    task automatic load_inst(input logic [4:0] s1, input logic [31:0] r1, input logic [4:0] s2,
                             input logic [31:0] r2, input logic [4:0] d, input logic [3:0] cmd,
                             input logic mr, input logic mw, input logic wb);
        in_valid = 1; src1_in = s1; reg1_in = r1; src2_in = s2; reg2_in = r2; dest_in = d;
        exe_cmd_in = cmd; mem_read_in = mr; mem_write_in = mw; wb_en_in = wb;
        is_imm_in = 0; imm_in = 32'h0;
        tick();
        in_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; in_valid = 1; src1_in = 5; reg1_in = 32'hDEAD; wb_en_in = 1; exe_cmd_in = 4'hF;
        tick();
        tick();
        rst = 0;
        #1;
        checks++;
        if (obs_fwd() !== out_t'(0)) begin
            failures++; $display("FAIL reset_fwd got=%h want=0", obs_fwd());
        end
        checks++;
        if (obs_raw() !== out_t'(0)) begin
            failures++; $display("FAIL reset_raw got=%h want=0", obs_raw());
        end
    endtask

    task automatic test_load_add();
        freeze = 1;  // hold through setup so the load edge is the only one that matters
        tick();
        freeze = 0;
        load_inst(5'd3, 32'd10, 5'd4, 32'd5, 5'd9, CMD_ADD, 1'b0, 1'b0, 1'b1);
        checks++;
        if (a_val1 !== 32'd10 || a_val2 !== 32'd5 || a_cmd !== CMD_ADD || a_valid !== 1'b1 || a_wb !== 1'b1) begin
            failures++;
            $display("FAIL load_add got val1=%0d val2=%0d cmd=%h valid=%b wb=%b want 10 5 1 1 1",
                     a_val1, a_val2, a_cmd, a_valid, a_wb);
        end
        checks++;
        if (obs_fwd() !== ref_out(1'b1, m_fwd)) begin
            failures++; $display("FAIL load_add_model got=%h want=%h", obs_fwd(), ref_out(1'b1, m_fwd));
        end
    endtask

    task automatic test_forward_priority();
        freeze = 1;
        load_inst(5'd7, 32'h11, 5'd1, 32'h22, 5'd2, CMD_ADD, 1'b0, 1'b0, 1'b1);
        freeze = 0;
        // First call ran with freeze=1 so nothing loaded; load for real now.
        load_inst(5'd7, 32'h11, 5'd1, 32'h22, 5'd2, CMD_ADD, 1'b0, 1'b0, 1'b1);
        mem_fwd_en = 1; mem_fwd_dest = 7; mem_fwd_val = 32'hAA;
        wb_fwd_en = 1;  wb_fwd_dest = 7;  wb_fwd_val = 32'hBB;
        #1;
        checks++;
        if (a_val1 !== 32'hAA) begin
            failures++; $display("FAIL fwd_mem_prio got=%h want=000000aa", a_val1);
        end
        checks++;
        if (b_val1 !== 32'h11) begin
            failures++; $display("FAIL fwd_disabled got=%h want=00000011", b_val1);
        end
        mem_fwd_en = 0;
        #1;
        checks++;
        if (a_val1 !== 32'hBB) begin
            failures++; $display("FAIL fwd_wb got=%h want=000000bb", a_val1);
        end
        mem_fwd_en = 1; mem_fwd_dest = 0; wb_fwd_dest = 0;
        load_inst(5'd0, 32'h77, 5'd0, 32'h66, 5'd2, CMD_ADD, 1'b0, 1'b0, 1'b1);
        checks++;
        if (a_val1 !== 32'h77 || a_st_val !== 32'h66) begin
            failures++; $display("FAIL fwd_reg0 got val1=%h st=%h want 00000077 00000066", a_val1, a_st_val);
        end
        idle_inputs();
    endtask

    task automatic test_imm_store();
        in_valid = 1; src1_in = 1; reg1_in = 32'h3; src2_in = 2; reg2_in = 32'h9; dest_in = 0;
        imm_in = 32'hFFFF_FFFC; is_imm_in = 1; mem_write_in = 1; exe_cmd_in = CMD_ADD;
        tick();
        in_valid = 0;
        mem_fwd_en = 1; mem_fwd_dest = 2; mem_fwd_val = 32'h55;
        #1;
        checks++;
        if (a_val2 !== 32'hFFFF_FFFC || a_st_val !== 32'h55) begin
            failures++; $display("FAIL imm_store got val2=%h st=%h want fffffffc 00000055", a_val2, a_st_val);
        end
        checks++;
        if (b_st_val !== 32'h9 || a_mw !== 1'b1) begin
            failures++; $display("FAIL store_raw got st=%h mw=%b want 00000009 1", b_st_val, a_mw);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        load_inst(5'd1, 32'h0, 5'd2, 32'h0, 5'd8, CMD_LW, 1'b1, 1'b0, 1'b1);
        id_src1 = 3; id_src2 = 8; id_src2_used = 1;
        #1;
        checks++;
        if (a_haz !== 1'b1 || b_haz !== 1'b1) begin
            failures++; $display("FAIL lu_src2 got fwd=%b raw=%b want 1 1", a_haz, b_haz);
        end
        id_src2_used = 0;
        #1;
        checks++;
        if (a_haz !== 1'b0 || b_haz !== 1'b0) begin
            failures++; $display("FAIL lu_unused got fwd=%b raw=%b want 0 0", a_haz, b_haz);
        end
        load_inst(5'd1, 32'h0, 5'd2, 32'h0, 5'd0, CMD_LW, 1'b1, 1'b0, 1'b1);
        id_src1 = 0; id_src2 = 0; id_src2_used = 1;
        #1;
        checks++;
        if (a_haz !== 1'b0 || b_haz !== 1'b0) begin
            failures++; $display("FAIL lu_dest0 got fwd=%b raw=%b want 0 0", a_haz, b_haz);
        end
        load_inst(5'd1, 32'h0, 5'd2, 32'h0, 5'd9, CMD_ADD, 1'b0, 1'b0, 1'b1);
        id_src1 = 9; id_src2_used = 0;
        #1;
        checks++;
        if (a_haz !== 1'b0 || b_haz !== 1'b1) begin
            failures++; $display("FAIL alu_use got fwd=%b raw=%b want 0 1", a_haz, b_haz);
        end
        idle_inputs();
    endtask

    task automatic test_freeze_capture();
        load_inst(5'd6, 32'h1, 5'd0, 32'h0, 5'd4, CMD_ADD, 1'b0, 1'b0, 1'b1);
        wb_fwd_en = 1; wb_fwd_dest = 6; wb_fwd_val = 32'h1234; freeze = 1;
        tick();
        wb_fwd_en = 0;
        #1;
        checks++;
        if (a_val1 !== 32'h1234 || b_val1 !== 32'h1) begin
            failures++; $display("FAIL freeze_capture got fwd=%h raw=%h want 00001234 00000001", a_val1, b_val1);
        end
        tick();
        checks++;
        if (a_val1 !== 32'h1234 || a_valid !== 1'b1) begin
            failures++; $display("FAIL freeze_hold got val1=%h valid=%b want 00001234 1", a_val1, a_valid);
        end
        idle_inputs();
    endtask

    task automatic test_flush_and_reset();
        load_inst(5'd1, 32'h5, 5'd2, 32'h6, 5'd3, CMD_ADD, 1'b0, 1'b1, 1'b1);
        freeze = 1; flush = 1;
        tick();
        freeze = 0; flush = 0;
        checks++;
        if (a_valid !== 1'b0 || a_wb !== 1'b0 || a_mw !== 1'b0) begin
            failures++; $display("FAIL flush_freeze got valid=%b wb=%b mw=%b want 0 0 0", a_valid, a_wb, a_mw);
        end
        load_inst(5'd1, 32'h5, 5'd2, 32'h6, 5'd3, CMD_LW, 1'b1, 1'b0, 1'b1);
        freeze = 1;
        tick();
        rst = 1;
        tick();
        rst = 0; freeze = 0;
        #1;
        checks++;
        if (obs_fwd() !== out_t'(0) || obs_raw() !== out_t'(0)) begin
            failures++; $display("FAIL rst_mid_freeze got fwd=%h raw=%h want 0", obs_fwd(), obs_raw());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 99) < 3);
            flush        = ($urandom_range(0, 99) < 10);
            freeze       = ($urandom_range(0, 99) < 25);
            in_valid     = ($urandom_range(0, 99) < 80);
            src1_in      = 5'($urandom_range(0, 3));
            src2_in      = 5'($urandom_range(0, 3));
            dest_in      = 5'($urandom_range(0, 3));
            reg1_in      = $urandom;
            reg2_in      = $urandom;
            imm_in       = $urandom;
            is_imm_in    = 1'($urandom);
            exe_cmd_in   = 4'($urandom);
            mem_read_in  = 1'($urandom);
            mem_write_in = 1'($urandom);
            wb_en_in     = 1'($urandom);
            id_src1      = 5'($urandom_range(0, 3));
            id_src2      = 5'($urandom_range(0, 3));
            id_src2_used = 1'($urandom);
            mem_fwd_en   = 1'($urandom);
            mem_fwd_dest = 5'($urandom_range(0, 3));
            mem_fwd_val  = $urandom;
            wb_fwd_en    = 1'($urandom);
            wb_fwd_dest  = 5'($urandom_range(0, 3));
            wb_fwd_val   = $urandom;
            #1;
            checks++;
            if (obs_fwd() !== ref_out(1'b1, m_fwd)) begin
                failures++; $display("FAIL rand_fwd cyc=%0d got=%h want=%h", i, obs_fwd(), ref_out(1'b1, m_fwd));
            end
            checks++;
            if (obs_raw() !== ref_out(1'b0, m_raw)) begin
                failures++; $display("FAIL rand_raw cyc=%0d got=%h want=%h", i, obs_raw(), ref_out(1'b0, m_raw));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        m_fwd = '0;
        m_raw = '0;
        idle_inputs();
        test_reset();
        test_load_add();
        test_forward_priority();
        test_imm_store();
        test_load_use();
        test_freeze_capture();
        test_flush_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
